ae_hit_ctrl: RTL and testbench
==============================

Name: ae_hit_ctrl

Overview:
- Acoustic-emission hit sequencer in the clk_10M ADC domain.
- Watches the sample stream for a threshold crossing and captures a fixed-length hit into the clk_10M write side of the async FIFO that feeds /dev/xillybus_read_32.
- Closes each hit with a two-word trailer (marker plus status) and enforces a dead time before re-arming.
- Arms only while the host holds the read stream open.

Parameters:
- DW, 16, sample and FIFO word width.
- HIT_LEN, 256, samples per hit, 1..65535.
- DEAD_LEN, 64, dead-time cycles after the trailer, 0..65535.
- MARKER, 16'hA55A, first trailer word.

Ports:
- clk_10M  in  1  acquisition clock.
- RESET  in  1  asynchronous reset, active-high.
- stream_open  in  1  read-stream open flag from the bus_clk domain; asynchronous to clk_10M.
- adc_valid  in  1  sample strobe, may be high every cycle.
- adc_data  in  DW  unsigned sample.
- threshold  in  DW  unsigned trigger level, quasi-static.
- fifo_full  in  1  FIFO full flag, write-clock domain.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_din  out  DW  FIFO write data.
- busy  out  1  high in CAPTURE, TRAIL0, TRAIL1 and DEAD.
- hit_count  out  16  hits accepted since arm.
- drop_count  out  16  hits rejected since arm.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal request register clear.
- stream_open passes through a 2-FF synchronizer to give open_s. Synchronizer flops reset to 0.
- Write path:
  - Internal registers req_q and data_q.
  - fifo_din = data_q.
  - fifo_wr_en = req_q && !fifo_full (combinational).
  - A word is "accepted" when fifo_wr_en = 1.
  - Latency from sample input to fifo_wr_en is 1 cycle.
- IDLE:
  - Outputs quiet; hit_count and drop_count cleared.
  - Go to ARMED when open_s = 1.
- ARMED: trigger = adc_valid && adc_data >= threshold.
  - Trigger with fifo_full = 0: hit_count++ (wraps), set req_q/data_q to the triggering sample (it is sample 0), sample counter = 1, clear trunc, go to CAPTURE.
  - Trigger with fifo_full = 1: drop_count++ (saturates at 16'hFFFF), nothing written, go to DEAD.
- CAPTURE:
  - Each adc_valid sample loads req_q/data_q and increments the sample counter.
  - If req_q = 1 and fifo_full = 1, that word is lost and trunc is set. Capture continues; it does not stall.
  - When the counter reaches HIT_LEN and that sample is loaded, go to TRAIL0.
  - HIT_LEN = 1 goes directly from ARMED to TRAIL0.
- TRAIL0:
  - Present MARKER with req_q = 1. Hold it until accepted, then go to TRAIL1.
  - adc_valid samples are ignored here.
  - The last capture word, if still pending, must first be given its acceptance cycle; it is never overwritten by the trailer.
- TRAIL1:
  - Present {trunc, hit_count[14:0]} and hold until accepted.
  - Then load the dead counter and go to DEAD; if DEAD_LEN = 0, go to ARMED.
- DEAD:
  - Count DEAD_LEN cycles; triggers are ignored.
  - Then go to ARMED.
- open_s falling in any state:
  - Next cycle goes to IDLE and clears req_q, so no further writes.
  - A partial hit is abandoned. The FIFO is being reset by the host close anyway.
- Reset mid-hit: immediate return to the reset values.
- Equal compare: adc_data == threshold triggers.
- threshold = 0 triggers on the first valid sample after arming.

Test Plan:
- Open, threshold = 16'h0800, feed ramp 0x0000 step 0x0100 every cycle, HIT_LEN = 4:
  - Writes are 0x0800, 0x0900, 0x0A00, 0x0B00, 0xA55A, 0x8001 → 0x0001.
  - fifo_wr_en first rises 1 cycle after the 0x0800 sample.
  - hit_count = 1.
- Same stimulus, DEAD_LEN = 64:
  - Second hit's first word is the first sample ≥ threshold at least 64 cycles after the trailer.
  - Trailer 2 = 0x0002.
- Hold fifo_full = 1 during the trigger cycle:
  - No write occurs, drop_count = 1, busy high for DEAD_LEN cycles, then re-arms.
- Assert fifo_full for 2 cycles mid-capture:
  - Exactly 2 samples are missing.
  - Trailer word 2 has bit15 = 1.
  - Trailer words wait until full clears and are then written once each.
- Deassert stream_open mid-capture:
  - fifo_wr_en is 0 within 3 clk_10M cycles (2 sync + 1).
  - State is IDLE and counters are 0.
  - On reopen, re-arms and hit_count restarts at 1.
- Assert RESET mid-TRAIL0:
  - All outputs are 0 asynchronously.
  - After release with stream_open = 1, ARMED is reached within 3 cycles.

Source files
------------

// File: rtl/ae_hit_ctrl.sv
// ae_hit_ctrl: acoustic-emission hit sequencer in the clk_10M ADC domain.
// Arms while the host keeps the read stream open. Each threshold crossing
// captures HIT_LEN samples into the async FIFO write side. A marker word and a
// status word {trunc, hit_count[14:0]} close the hit, then a dead time runs
// before the block re-arms.
module ae_hit_ctrl #(
  parameter int              DW       = 16,
  parameter int              HIT_LEN  = 256,
  parameter int              DEAD_LEN = 64,
  parameter logic [DW-1:0]   MARKER   = 16'hA55A
) (
  input  logic          clk_10M,
  input  logic          RESET,
  input  logic          stream_open,
  input  logic          adc_valid,
  input  logic [DW-1:0] adc_data,
  input  logic [DW-1:0] threshold,
  input  logic          fifo_full,
  output logic          fifo_wr_en,
  output logic [DW-1:0] fifo_din,
  output logic          busy,
  output logic [15:0]   hit_count,
  output logic [15:0]   drop_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    TRAIL0  = 3'd3,
    TRAIL1  = 3'd4,
    DEAD    = 3'd5
  } state_t;

  // Index of the last sample in a hit, and the dead-time reload value.
  localparam logic [15:0] HIT_LAST  = 16'(HIT_LEN - 1);
  localparam logic [15:0] DEAD_INIT = 16'(DEAD_LEN);
  localparam bit          HIT_ONE   = (HIT_LEN == 1);
  localparam bit          DEAD_ZERO = (DEAD_LEN == 0);

  // Registered state and datapath.
  state_t        state_q, state_n;
  logic          open_meta, open_s;
  logic          req_q, req_n;
  logic [DW-1:0] data_q, data_n;
  logic [15:0]   cnt_q, cnt_n;
  logic [15:0]   dead_q, dead_n;
  logic          trunc_q, trunc_n;
  logic          mark_q, mark_n;
  logic [15:0]   hit_q, hit_n;
  logic [15:0]   drop_q, drop_n;
  logic          busy_q, busy_n;

  logic          trigger_s;
  logic          accepted_s;
  logic          lost_s;
  logic [15:0]   status_s;

  // A pending word is written whenever the FIFO has room; a full FIFO in the
  // same cycle means that word is either held (trailer) or lost (capture).
  assign accepted_s = req_q & ~fifo_full;
  assign lost_s     = req_q & fifo_full;
  assign trigger_s  = adc_valid & (adc_data >= threshold);
  assign status_s   = {trunc_q, hit_q[14:0]};

  assign fifo_wr_en = accepted_s;
  assign fifo_din   = data_q;
  assign busy       = busy_q;
  assign hit_count  = hit_q;
  assign drop_count = drop_q;

  // Two-flop synchronizer bringing the bus_clk stream-open flag into clk_10M.
  always_ff @(posedge clk_10M or posedge RESET) begin
    if (RESET) begin
      open_meta <= 1'b0;
      open_s    <= 1'b0;
    end else begin
      open_meta <= stream_open;
      open_s    <= open_meta;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_10M or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= 16'd0;
      dead_q  <= 16'd0;
      trunc_q <= 1'b0;
      mark_q  <= 1'b0;
      hit_q   <= 16'd0;
      drop_q  <= 16'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      req_q   <= req_n;
      data_q  <= data_n;
      cnt_q   <= cnt_n;
      dead_q  <= dead_n;
      trunc_q <= trunc_n;
      mark_q  <= mark_n;
      hit_q   <= hit_n;
      drop_q  <= drop_n;
      busy_q  <= busy_n;
    end
  end

  // Next-state and write-request logic; a closed stream overrides every state.
  always_comb begin
    state_n = state_q;
    req_n   = req_q;
    data_n  = data_q;
    cnt_n   = cnt_q;
    dead_n  = dead_q;
    trunc_n = trunc_q;
    mark_n  = mark_q;
    hit_n   = hit_q;
    drop_n  = drop_q;

    if (!open_s) begin
      state_n = IDLE;
      req_n   = 1'b0;
      hit_n   = 16'd0;
      drop_n  = 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          req_n   = 1'b0;
          hit_n   = 16'd0;
          drop_n  = 16'd0;
          state_n = ARMED;
        end

        ARMED: begin
          req_n = 1'b0;
          if (trigger_s) begin
            if (!fifo_full) begin
              hit_n   = hit_q + 16'd1;
              req_n   = 1'b1;
              data_n  = adc_data;
              cnt_n   = 16'd1;
              trunc_n = 1'b0;
              mark_n  = 1'b0;
              state_n = HIT_ONE ? TRAIL0 : CAPTURE;
            end else begin
              // No room for sample 0: the whole hit is dropped.
              drop_n  = (drop_q != 16'hFFFF) ? (drop_q + 16'd1) : drop_q;
              dead_n  = DEAD_INIT;
              state_n = DEAD_ZERO ? ARMED : DEAD;
            end
          end else begin
            state_n = ARMED;
          end
        end

        CAPTURE: begin
          if (lost_s) begin
            trunc_n = 1'b1;
          end else begin
            trunc_n = trunc_q;
          end
          if (adc_valid) begin
            req_n  = 1'b1;
            data_n = adc_data;
            if (cnt_q == HIT_LAST) begin
              mark_n  = 1'b0;
              state_n = TRAIL0;
            end else begin
              cnt_n = cnt_q + 16'd1;
            end
          end else begin
            req_n = 1'b0;
          end
        end

        TRAIL0: begin
          if (!mark_q) begin
            // The last capture word gets its one acceptance cycle here.
            if (lost_s) begin
              trunc_n = 1'b1;
            end else begin
              trunc_n = trunc_q;
            end
            req_n  = 1'b1;
            data_n = MARKER;
            mark_n = 1'b1;
          end else if (accepted_s) begin
            req_n   = 1'b1;
            data_n  = DW'(status_s);
            state_n = TRAIL1;
          end else begin
            req_n = 1'b1;
          end
        end

        TRAIL1: begin
          if (accepted_s) begin
            req_n   = 1'b0;
            dead_n  = DEAD_INIT;
            state_n = DEAD_ZERO ? ARMED : DEAD;
          end else begin
            req_n = 1'b1;
          end
        end

        DEAD: begin
          req_n = 1'b0;
          if (dead_q <= 16'd1) begin
            state_n = ARMED;
          end else begin
            dead_n = dead_q - 16'd1;
          end
        end

        default: begin
          state_n = IDLE;
          req_n   = 1'b0;
        end
      endcase
    end

    busy_n = (state_n == CAPTURE) || (state_n == TRAIL0) ||
             (state_n == TRAIL1)  || (state_n == DEAD);
  end

endmodule

// File: tb/tb_ae_hit_ctrl.sv
// Directed bench for ae_hit_ctrl (HIT_LEN = 4, DEAD_LEN = 64).
module tb_ae_hit_ctrl;

  logic        clk_10M = 1'b0;
  logic        RESET;
  logic        stream_open;
  logic        adc_valid;
  logic [15:0] adc_data;
  logic [15:0] threshold;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [15:0] fifo_din;
  logic        busy;
  logic [15:0] hit_count;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [15:0] wq[$];
  int          ws[$];

  ae_hit_ctrl #(.DW(16), .HIT_LEN(4), .DEAD_LEN(64), .MARKER(16'hA55A)) dut (
    .clk_10M    (clk_10M),
    .RESET      (RESET),
    .stream_open(stream_open),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .threshold  (threshold),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .busy       (busy),
    .hit_count  (hit_count),
    .drop_count (drop_count)
  );

  // 10 MHz clock.
  always #50 clk_10M = ~clk_10M;

  // Cycle stamp used to time-tag writes.
  always @(posedge clk_10M) cyc <= cyc + 1;

  // Record every accepted FIFO word, sampled mid-cycle.
  always @(negedge clk_10M) begin
    if (fifo_wr_en === 1'b1) begin
      wq.push_back(fifo_din);
      ws.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_10M);
    #1;
  endtask

  logic [15:0] exp1 [12] = '{16'h0800, 16'h0900, 16'h0A00, 16'h0B00, 16'hA55A, 16'h0001,
                             16'h4F00, 16'h5000, 16'h5100, 16'h5200, 16'hA55A, 16'h0002};
  logic [15:0] exp4 [4]  = '{16'h1200, 16'h1300, 16'hA55A, 16'h8003};

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k0;
    int n0;
    int bcnt;
    RESET = 1'b1; stream_open = 1'b0; adc_valid = 1'b0; adc_data = 16'h0000;
    threshold = 16'h0800; fifo_full = 1'b0;
    #20;
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_din",   32'(fifo_din),   32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_hits",  32'(hit_count),  32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    tick(); tick();
    RESET = 1'b0;
    stream_open = 1'b1;
    repeat (5) tick();

    // Ramp: two hits separated by the dead time.
    k0 = 0;
    for (int i = 0; i < 100; i++) begin
      adc_valid = 1'b1;
      adc_data  = 16'(i * 256);
      if (i == 8) k0 = cyc;
      tick();
    end
    adc_valid = 1'b0;
    repeat (80) tick();
    chk("ramp_nwords", 32'(wq.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < wq.size()) chk($sformatf("ramp_word%0d", i), 32'(wq[i]), 32'(exp1[i]));
    end
    if (ws.size() >= 7) begin
      chk("first_wr_lat", 32'(ws[0]), 32'(k0 + 1));
      chk("hit2_start",   32'(ws[6]), 32'(k0 + 72));
    end
    chk("ramp_hits", 32'(hit_count), 32'd2);
    chk("ramp_busy", 32'(busy), 32'd0);

    // Trigger while the FIFO is full: dropped hit, dead time only.
    fifo_full = 1'b1; adc_valid = 1'b1; adc_data = 16'h0900;
    tick();
    fifo_full = 1'b0; adc_valid = 1'b0;
    chk("drop_busy_now", 32'(busy), 32'd1);
    bcnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (busy) bcnt++;
      tick();
    end
    chk("drop_busy_len", 32'(bcnt), 32'd64);
    chk("drop_count", 32'(drop_count), 32'd1);
    chk("drop_nwords", 32'(wq.size()), 32'd12);
    chk("drop_hits", 32'(hit_count), 32'd2);

    // Full for two capture cycles and two trailer cycles.
    n0 = wq.size();
    for (int i = 0; i < 4; i++) begin
      adc_valid = 1'b1;
      adc_data  = 16'(16'h1000 + i * 256);
      fifo_full = (i == 1) || (i == 2);
      tick();
    end
    adc_valid = 1'b0; fifo_full = 1'b0;
    tick();
    fifo_full = 1'b1;
    tick(); tick();
    fifo_full = 1'b0;
    repeat (10) tick();
    chk("trunc_nwords", 32'(wq.size()), 32'(n0 + 4));
    for (int i = 0; i < 4; i++) begin
      if (n0 + i < wq.size()) chk($sformatf("trunc_word%0d", i), 32'(wq[n0 + i]), 32'(exp4[i]));
    end
    chk("trunc_hits", 32'(hit_count), 32'd3);
    repeat (70) tick();

    // Close the stream mid-capture.
    n0 = wq.size();
    for (int i = 0; i < 4; i++) begin
      adc_valid = 1'b1;
      adc_data  = 16'(16'h2000 + i * 256);
      if (i == 1) stream_open = 1'b0;
      tick();
    end
    adc_valid = 1'b0;
    chk("close_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("close_busy",  32'(busy),       32'd0);
    chk("close_hits",  32'(hit_count),  32'd0);
    chk("close_drops", 32'(drop_count), 32'd0);
    repeat (5) tick();
    chk("close_nwords", 32'(wq.size()), 32'(n0 + 3));
    if (n0 + 2 < wq.size()) begin
      chk("close_word0", 32'(wq[n0]),     32'h2000);
      chk("close_word2", 32'(wq[n0 + 2]), 32'h2200);
    end

    // Reopen, start a hit, stall in TRAIL0, then reset asynchronously.
    stream_open = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 4; i++) begin
      adc_valid = 1'b1;
      adc_data  = 16'(16'h3000 + i * 256);
      tick();
    end
    adc_valid = 1'b0; fifo_full = 1'b1;
    tick(); tick();
    chk("reopen_hits", 32'(hit_count), 32'd1);
    chk("trail0_busy", 32'(busy), 32'd1);
    RESET = 1'b1; fifo_full = 1'b0;
    #2;
    chk("arst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("arst_din",   32'(fifo_din),   32'd0);
    chk("arst_busy",  32'(busy),       32'd0);
    chk("arst_hits",  32'(hit_count),  32'd0);
    chk("arst_drops", 32'(drop_count), 32'd0);
    tick(); tick();
    RESET = 1'b0;
    repeat (3) tick();
    adc_valid = 1'b1; adc_data = 16'h4000;
    tick();
    adc_valid = 1'b0;
    chk("rearm_wr_en", 32'(fifo_wr_en), 32'd1);
    chk("rearm_din",   32'(fifo_din),   32'h4000);
    chk("rearm_hits",  32'(hit_count),  32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
